// File: rtl/multicycle_pkg.sv
// Shared constants for the multi-cycle RV32I-subset control sequencer:
// opcodes, ALU-op classes, ALU B-operand selects, state encodings and the control vector.
package multicycle_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC_R = 4'd2;
    localparam logic [3:0] ST_WB_R   = 4'd3;
    localparam logic [3:0] ST_ADDR   = 4'd4;
    localparam logic [3:0] ST_MEM_LD = 4'd5;
    localparam logic [3:0] ST_WB_LD  = 4'd6;
    localparam logic [3:0] ST_MEM_ST = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_TRAP   = 4'd9;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state-to-control-vector decoder, including the Mealy
// terms on mem_ready (FETCH) and zero (BRANCH).
module multicycle_ctrl_decode
    import multicycle_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_WB_R: ctrl.reg_write = 1'b1;
            ST_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_LD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_WB_LD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_ST: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = 1'b1;
                ctrl.pc_write  = zero;
            end
            // TRAP and every unused encoding: flag illegal, no strobes
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: state register, next-state logic and reset gating.
// Define MULTICYCLE_CTRL_PERF_EN to add retired_cnt / stall_cnt performance counters.
module multicycle_ctrl_fsm
    import multicycle_pkg::*;
#(
    parameter int OPCODE_W = 7,
`ifdef MULTICYCLE_CTRL_PERF_EN
    parameter int PERF_W   = 32,
`endif
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal,
`ifdef MULTICYCLE_CTRL_PERF_EN
    output logic [PERF_W-1:0]   retired_cnt,
    output logic [PERF_W-1:0]   stall_cnt,
`endif
    output logic [3:0]          state_o
);

    logic [3:0] state;
    logic [3:0] state_nxt;
    ctrl_t      ctrl_dec;
    ctrl_t      ctrl;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:  if (mem_ready) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OPCODE_W'(OP_RTYPE))
                    state_nxt = ST_EXEC_R;
                else if (opcode == OPCODE_W'(OP_LOAD) || opcode == OPCODE_W'(OP_STORE))
                    state_nxt = ST_ADDR;
                else if (opcode == OPCODE_W'(OP_BRANCH))
                    state_nxt = ST_BRANCH;
                else
                    state_nxt = ST_TRAP;
            end
            ST_EXEC_R: state_nxt = ST_WB_R;
            ST_WB_R:   state_nxt = ST_FETCH;
            ST_ADDR:   state_nxt = (opcode == OPCODE_W'(OP_STORE)) ? ST_MEM_ST : ST_MEM_LD;
            ST_MEM_LD: if (mem_ready) state_nxt = ST_WB_LD;
            ST_WB_LD:  state_nxt = ST_FETCH;
            ST_MEM_ST: if (mem_ready) state_nxt = ST_FETCH;
            ST_BRANCH: state_nxt = ST_FETCH;
            default:   state_nxt = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    multicycle_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl_dec)
    );

    // Reset held low kills every strobe and select so an aborted access leaves no side effect
    always_comb begin
        ctrl = ctrl_dec;
        if (!rst_n) begin
            ctrl         = '0;
            ctrl.illegal = ctrl_dec.illegal;
        end
    end

    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ALU_OP_W'(ctrl.alu_op);
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign illegal    = ctrl.illegal;
    assign state_o    = state;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic retire;
    logic stall;

    assign retire = (state_nxt == ST_FETCH) &&
                    (state == ST_WB_R || state == ST_WB_LD || state == ST_MEM_ST || state == ST_BRANCH);
    assign stall  = !mem_ready && (state == ST_FETCH || state == ST_MEM_LD || state == ST_MEM_ST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (retire) retired_cnt <= retired_cnt + PERF_W'(1);
            if (stall)  stall_cnt   <= stall_cnt + PERF_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: a per-phase behavioural model feeds an
// expected queue that is compared every cycle, plus literal latency and count checks.
module tb_multicycle_ctrl_fsm;
    import multicycle_pkg::*;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;
    localparam int         W      = 18;

    typedef enum int {P_FETCH, P_DECODE, P_EXEC_R, P_WB_R, P_ADDR,
                      P_MEM_LD, P_WB_LD, P_MEM_ST, P_BRANCH, P_TRAP} phase_e;
    typedef enum int {K_R, K_LD, K_ST, K_BR, K_TRAP} kind_e;
    typedef struct {
        string name;
        int    act;
        int    exp;
    } lit_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       ir_write, pc_write, pc_src, iord, mem_read, mem_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_to_reg, reg_write, illegal;
    logic [3:0] state_o;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    lit_t         chk_q[$];
    int           n_checks = 0;
    int           n_errors = 0;

    // cycle monitor state (written only by the compare process)
    int         ncyc = 0;
    int         last_entry = 0;
    logic [3:0] prev_st = 4'hF;
    int         cnt_rw = 0, cnt_rdiord = 0, cnt_wr = 0, cnt_pcw = 0;

    multicycle_ctrl_fsm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal),
`ifdef MULTICYCLE_CTRL_PERF_EN
        .retired_cnt(retired_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .state_o    (state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // expected outputs of one cycle, straight from the per-phase control table
    function automatic logic [W-1:0] model(input phase_e p, input logic rdy, input logic z,
                                           input bit rst_on);
        logic [3:0] st;
        logic       irw, pcw, pcs, io, mr, mw, asa, m2r, rw, ill;
        logic [1:0] asb, aop;
        {irw, pcw, pcs, io, mr, mw, asa, m2r, rw, ill} = '0;
        asb = 2'b00;
        aop = 2'b00;
        st  = ST_TRAP;
        case (p)
            P_FETCH:  begin st = ST_FETCH;  mr = 1'b1; asb = 2'b01; irw = rdy; pcw = rdy; end
            P_DECODE: begin st = ST_DECODE; asb = 2'b10; end
            P_EXEC_R: begin st = ST_EXEC_R; asa = 1'b1; aop = 2'b10; end
            P_WB_R:   begin st = ST_WB_R;   rw = 1'b1; end
            P_ADDR:   begin st = ST_ADDR;   asa = 1'b1; asb = 2'b10; end
            P_MEM_LD: begin st = ST_MEM_LD; mr = 1'b1; io = 1'b1; end
            P_WB_LD:  begin st = ST_WB_LD;  rw = 1'b1; m2r = 1'b1; end
            P_MEM_ST: begin st = ST_MEM_ST; mw = 1'b1; io = 1'b1; end
            P_BRANCH: begin st = ST_BRANCH; asa = 1'b1; aop = 2'b01; pcs = 1'b1; pcw = z; end
            default:  begin st = ST_TRAP;   ill = 1'b1; end
        endcase
        if (rst_on) begin
            {irw, pcw, pcs, io, mr, mw, asa, m2r, rw} = '0;
            asb = 2'b00;
            aop = 2'b00;
        end
        return {st, irw, pcw, pcs, io, mr, mw, asa, asb, aop, m2r, rw, ill};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // driver tasks
    task automatic cycle(input phase_e p, input logic rdy, input logic z, input bit rst_on,
                         input string nm);
        rst_n     = rst_on ? 1'b0 : 1'b1;
        mem_ready = rdy;
        zero      = z;
        exp_q.push_back(model(p, rdy, z, rst_on));
        tag_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic push_lit(input string nm, input int act, input int exp);
        chk_q.push_back('{name: nm, act: act, exp: exp});
    endtask

    // one instruction from FETCH entry; for K_TRAP, mw is the number of TRAP cycles observed
    task automatic run_instr(input kind_e k, input logic [6:0] opc, input int fw, input int mw,
                             input logic z, input bit idle, input int lat_exp, input string nm);
        int start;
        start = ncyc;
        for (int i = 0; i < fw; i++) begin
            opcode = 7'($urandom_range(0, 127));
            cycle(P_FETCH, 1'b0, rbit(), 1'b0, {nm, " fetch_wait"});
        end
        opcode = 7'($urandom_range(0, 127));
        cycle(P_FETCH, 1'b1, rbit(), 1'b0, {nm, " fetch"});
        opcode = opc;
        cycle(P_DECODE, rbit(), rbit(), 1'b0, {nm, " decode"});
        case (k)
            K_R: begin
                cycle(P_EXEC_R, rbit(), rbit(), 1'b0, {nm, " exec_r"});
                cycle(P_WB_R, rbit(), rbit(), 1'b0, {nm, " wb_r"});
            end
            K_LD: begin
                cycle(P_ADDR, rbit(), rbit(), 1'b0, {nm, " addr"});
                for (int i = 0; i < mw; i++) cycle(P_MEM_LD, 1'b0, rbit(), 1'b0, {nm, " mem_ld_wait"});
                cycle(P_MEM_LD, 1'b1, rbit(), 1'b0, {nm, " mem_ld"});
                cycle(P_WB_LD, rbit(), rbit(), 1'b0, {nm, " wb_ld"});
            end
            K_ST: begin
                cycle(P_ADDR, rbit(), rbit(), 1'b0, {nm, " addr"});
                for (int i = 0; i < mw; i++) cycle(P_MEM_ST, 1'b0, rbit(), 1'b0, {nm, " mem_st_wait"});
                cycle(P_MEM_ST, 1'b1, rbit(), 1'b0, {nm, " mem_st"});
            end
            K_BR: cycle(P_BRANCH, rbit(), z, 1'b0, {nm, " branch"});
            default: begin
                for (int i = 0; i < mw; i++) cycle(P_TRAP, rbit(), rbit(), 1'b0, {nm, " trap"});
            end
        endcase
        if (idle) begin
            opcode = 7'($urandom_range(0, 127));
            cycle(P_FETCH, 1'b0, rbit(), 1'b0, {nm, " idle"});
            if (lat_exp > 0) push_lit({nm, " latency"}, last_entry - start, lat_exp);
        end
    endtask

    // scoreboard: compares every driven cycle and drains literal checks
    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        string        t;
        lit_t         l;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {state_o, ir_write, pc_write, pc_src, iord, mem_read, mem_write, alu_src_a,
                 alu_src_b, alu_op, mem_to_reg, reg_write, illegal};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s: got state/ctrl %h required %h", t, a, e);
            end
            if (mem_read === 1'b1 && mem_write === 1'b1) begin
                n_errors++;
                $display("FAIL %s mem_rw_exclusive: got rd=1 wr=1 required not both", t);
            end
        end
        while (chk_q.size() > 0) begin
            l = chk_q.pop_front();
            n_checks++;
            if (l.act != l.exp) begin
                n_errors++;
                $display("FAIL %s: got %0d required %0d", l.name, l.act, l.exp);
            end
        end
        if (state_o === ST_FETCH && prev_st !== ST_FETCH) last_entry = ncyc;
        prev_st = state_o;
        if (reg_write === 1'b1) cnt_rw++;
        if (mem_read === 1'b1 && iord === 1'b1) cnt_rdiord++;
        if (mem_write === 1'b1) cnt_wr++;
        if (pc_write === 1'b1) cnt_pcw++;
        ncyc++;
    end

    initial begin
        int s;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle(P_FETCH, 1'b1, 1'b0, 1'b1, "reset_state");

        s = cnt_rw;
        run_instr(K_R, OPC_R, 0, 0, 1'b0, 1'b1, 4, "rtype");
        push_lit("rtype reg_write cycles", cnt_rw - s, 1);

        s = cnt_rdiord;
        run_instr(K_LD, OPC_LD, 0, 2, 1'b0, 1'b1, 7, "load_w2");
        push_lit("load_w2 mem_read iord cycles", cnt_rdiord - s, 3);

        s = cnt_wr;
        run_instr(K_ST, OPC_ST, 1, 2, 1'b0, 1'b1, 7, "store_f1_w2");
        push_lit("store_f1_w2 mem_write cycles", cnt_wr - s, 3);

        run_instr(K_ST, OPC_ST, 0, 0, 1'b0, 1'b1, 4, "store_w0");
        run_instr(K_LD, OPC_LD, 0, 0, 1'b0, 1'b1, 5, "load_w0");

        s = cnt_pcw;
        run_instr(K_BR, OPC_BR, 0, 0, 1'b1, 1'b1, 3, "branch_taken");
        push_lit("branch_taken pc_write cycles", cnt_pcw - s, 2);

        s = cnt_pcw;
        run_instr(K_BR, OPC_BR, 0, 0, 1'b0, 1'b1, 3, "branch_not_taken");
        push_lit("branch_not_taken pc_write cycles", cnt_pcw - s, 1);

        run_instr(K_R, OPC_R, 2, 0, 1'b0, 1'b1, 6, "rtype_f2");

        // unsupported opcodes trap and stay until a one-edge reset
        run_instr(K_TRAP, 7'b1111111, 0, 12, 1'b0, 1'b0, 0, "trap_7f");
        cycle(P_TRAP, rbit(), rbit(), 1'b1, "trap_7f reset");
        run_instr(K_R, OPC_R, 0, 0, 1'b0, 1'b1, 4, "after_trap");
        run_instr(K_TRAP, 7'b0010011, 0, 3, 1'b0, 1'b0, 0, "trap_13");
        cycle(P_TRAP, rbit(), rbit(), 1'b1, "trap_13 reset");

        // reset while a store is waiting on memory
        s = cnt_wr;
        opcode = 7'($urandom_range(0, 127));
        cycle(P_FETCH, 1'b1, rbit(), 1'b0, "rst_st fetch");
        opcode = OPC_ST;
        cycle(P_DECODE, rbit(), rbit(), 1'b0, "rst_st decode");
        cycle(P_ADDR, rbit(), rbit(), 1'b0, "rst_st addr");
        cycle(P_MEM_ST, 1'b0, rbit(), 1'b0, "rst_st wait");
        cycle(P_MEM_ST, 1'b0, rbit(), 1'b1, "rst_st reset");
        cycle(P_FETCH, 1'b0, rbit(), 1'b0, "rst_st after");
        push_lit("rst_st mem_write cycles", cnt_wr - s, 1);

        // back-to-back mix with three wait cycles in total
        cycle(P_FETCH, 1'b0, 1'b0, 1'b1, "perf reset");
        run_instr(K_R, OPC_R, 1, 0, 1'b0, 1'b0, 0, "perf_r");
        run_instr(K_LD, OPC_LD, 0, 1, 1'b0, 1'b0, 0, "perf_ld");
        run_instr(K_ST, OPC_ST, 0, 1, 1'b0, 1'b0, 0, "perf_st");
        run_instr(K_BR, OPC_BR, 0, 0, 1'b1, 1'b0, 0, "perf_br");
`ifdef MULTICYCLE_CTRL_PERF_EN
        push_lit("perf retired_cnt", int'(retired_cnt), 4);
        push_lit("perf stall_cnt", int'(stall_cnt), 3);
`endif
        run_instr(K_R, OPC_R, 0, 0, 1'b0, 1'b1, 4, "final_rtype");

        // final report
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I-subset datapath: R-type (0110011), load (0000011), store (0100011) and branch (1100011).
- Replaces single-cycle opcode decode with a state machine that shares one memory port and one ALU across fetch, execute and memory phases.
- Sits between the instruction register and the datapath muxes and enables.
- Memory accesses use a ready handshake, so wait states are supported.

Parameters:
- OPCODE_W, 7, opcode field width.
- ALU_OP_W, 2, ALU-op encoding width: 00 add, 01 sub/compare, 10 funct-decoded.
- PERF_W, 32, width of performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- opcode  in  OPCODE_W  IR[6:0], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current read/write this cycle.
- ir_write  out  1  load IR from memory read data.
- pc_write  out  1  unconditional PC update.
- pc_src  out  1  0 = PC+4, 1 = branch target register.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = const 4, 10 = immediate.
- alu_op  out  ALU_OP_W  ALU operation class.
- mem_to_reg  out  1  write-back select: 0 = ALU out, 1 = memory data register.
- reg_write  out  1  register-file write enable.
- illegal  out  1  sticky: unsupported opcode trapped.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- State is registered. Outputs are combinational from state, except for the Mealy terms on mem_ready and zero noted below.
- Reset: at any clk edge with rst_n=0, state=FETCH and illegal=0. While rst_n=0, every strobe output (ir_write, pc_write, mem_read, mem_write, reg_write) is forced 0 and mux selects are 0. Reset asserted mid-instruction aborts it with no register or memory side effect after that edge.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=0, next state DECODE.
  - Otherwise hold FETCH; ir_write=0, pc_write=0.
- DECODE: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target PC+imm into ALU register; old PC is held by the datapath). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - any other value -> TRAP
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next state WB_R.
- WB_R: reg_write=1, mem_to_reg=0. Next state FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEM_LD for load, MEM_ST for store.
- MEM_LD: mem_read=1, iord=1. Stays until mem_ready=1, then WB_LD.
- WB_LD: reg_write=1, mem_to_reg=1. Next state FETCH.
- MEM_ST: mem_write=1, iord=1. Stays until mem_ready=1, then FETCH. mem_write is held high for every wait cycle.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1. pc_write=zero in the same cycle (Mealy). Next state FETCH unconditionally.
- TRAP: illegal=1, all strobes 0. Stays in TRAP until reset.
- Latencies from FETCH entry with zero wait states: R-type 4 cycles, load 5, store 4, branch 3.
- Wait states add exactly one cycle each.
- mem_ready is ignored in every state other than FETCH, MEM_LD and MEM_ST.
- mem_read and mem_write are never asserted in the same cycle.
- Unused state encodings are treated as TRAP.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, add two outputs:
  - retired_cnt (PERF_W): increments on each transition into FETCH from WB_R, WB_LD, MEM_ST or BRANCH.
  - stall_cnt (PERF_W): increments on every cycle spent in FETCH, MEM_LD or MEM_ST with mem_ready=0.
  - Both counters clear on reset and wrap modulo 2^PERF_W.
- When undefined: no counters and no extra ports; all other behaviour is identical.

Decomposition:
- Shared package multicycle_pkg holds:
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALU-op constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - the 4-bit state encodings;
  - alu_src_b select constants.
- One natural sub-module: multicycle_ctrl_decode, the pure combinational state-to-control-vector decoder. The top keeps the state register, next-state logic and counters.

Test Plan:
- R-type, mem_ready tied 1, opcode=0110011 -> states FETCH, DECODE, EXEC_R, WB_R, FETCH. reg_write=1 only in cycle 4; alu_op=10 in cycle 3.
- Load with FETCH ready immediately and 2 wait cycles in MEM_LD -> mem_read high with iord=1 for 3 cycles; WB_LD has mem_to_reg=1, reg_write=1; total 7 cycles.
- Branch, opcode=1100011: zero=1 -> pc_write=1, pc_src=1 in BRANCH. zero=0 -> pc_write=0. Both return to FETCH after 3 cycles.
- opcode=1111111 -> TRAP after DECODE; illegal=1 held for 10+ cycles, strobes 0. rst_n=0 for one edge -> FETCH, illegal=0.
- rst_n=0 during MEM_ST with mem_ready=0 -> next cycle state FETCH with mem_write=0; no write is observed.
- With MULTICYCLE_CTRL_PERF_EN: run R, load, store, branch with 3 total wait cycles -> retired_cnt=4, stall_cnt=3.
